mult_div_sequencer: RTL and testbench
=====================================

// Module: mult_div_sequencer
// PURPOSE
//  Iterative multiply/divide engine with its own sequencer, shared by the main control FSM for MULT/DIV.
//  Accepts a one-cycle start with operands rs/rt. Runs WIDTH shift-add or restoring-divide steps.
//  Signals done or div0 on completion. Holds results in HI/LO registers, read by MFHI/MFLO via mem_to_reg mux.
// PARAMETERS
//  WIDTH   32  operand width; HI/LO are WIDTH each
//  CNT_W   6   step-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clock   in   1      clock, rising edge
//  reset   in   1      synchronous, active-high
//  start   in   1      request pulse; sampled only in IDLE
//  op      in   2      [0]: 0=MULT, 1=DIV; [1]: unsigned (see CONFIGURATION)
//  a       in   WIDTH  multiplicand / dividend (rs)
//  b       in   WIDTH  multiplier / divisor (rt)
//  busy    out  1      high from the cycle after start is accepted until done/div0 cycle inclusive
//  done    out  1      one-cycle pulse; hi/lo hold new result in the same cycle
//  div0    out  1      one-cycle pulse; DIV with b==0; hi/lo unchanged
//  hi      out  WIDTH  HI register (product[2W-1:W] / remainder)
//  lo      out  WIDTH  LO register (product[W-1:0] / quotient)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, div0=0, hi=0, lo=0, counter=0. Reset mid-operation aborts and discards the work.
//  States:
//   IDLE -> LOAD when start=1. Latch op, |a|, |b|, sign(a), sign(b).
//   LOAD -> if DIV && b==0: ZERO; else CALC, counter=0.
//   CALC -> WIDTH iterations, one per cycle; counter==WIDTH-1 -> FIX.
//   FIX  -> conditional negate of result -> DONE.
//   DONE -> write hi/lo, done=1 -> IDLE.
//   ZERO -> div0=1 -> IDLE.
//  Latency: start at cycle T -> done at T+WIDTH+3 (T+35 @32). div0 at T+2.
//  start while busy: ignored, with no queueing. op, a, b are sampled only on the accepting edge.
//  MULT: {hi,lo} = a*b as a 2W-bit signed product. Negate the product iff sign(a)^sign(b).
//  DIV: restoring division on magnitudes.
//   Negate the quotient iff sign(a)^sign(b). Remainder takes sign(a).
//  Overflow case: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (wraps, no flag).
//  MULT never raises div0. done and div0 are mutually exclusive.
//  hi/lo change only in DONE or on reset.
// CONFIGURATION
//  MULT_DIV_UNSIGNED_EN defined:
//   op[1]=1 selects MULTU/DIVU: no magnitude conversion, FIX does not negate.
//  Not defined: op[1] is ignored and all operations are signed. FIX logic always applies.
// STRUCTURE
//  mult_div_pkg:
//   state encoding (IDLE, LOAD, CALC, FIX, DONE, ZERO);
//   op bit positions OP_DIV=0, OP_UNS=1;
//   localparam default WIDTH.
//  Sub-module mult_div_datapath:
//   holds the 2W-bit accumulator/remainder shift register, the W-bit operand register, the adder/subtractor and the conditional negator.
//   Driven by load/step/fix/is_div strobes from this FSM.
//  The top level keeps the FSM, the step counter, busy/done/div0 and the hi/lo registers.
// TESTING
//  MULT a=7,b=-3 -> done at T+35, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high T+1..T+35.
//  DIV a=-7,b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); done pulse exactly 1 cycle.
//  DIV a=5,b=0 -> div0 at T+2, no done, hi/lo keep prior values, busy drops after.
//  MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0. Then DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  start re-pulsed at T+5 with different operands -> ignored, first result intact.
//  reset at T+10 of a MULT -> next cycle IDLE, hi=lo=0. A new start completes normally.
//  With MULT_DIV_UNSIGNED_EN: op=2'b11, a=0xFFFFFFFF, b=2 -> lo=0x7FFFFFFF, hi=1.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam int OP_DIV = 0;
    localparam int OP_UNS = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        FIX,
        DONE,
        ZERO
    } state_t;

endpackage

// File: rtl/mult_div_datapath.sv
// Shift-add multiply / restoring divide datapath with result sign correction.
module mult_div_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_fix,
    input  logic               i_is_div,
    input  logic               i_neg_q,
    input  logic               i_neg_r,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_b_zero,
    output logic [2*WIDTH-1:0] o_fixed
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_next_acc;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // Multiply: lo half holds the multiplier, shifted out LSB-first.
    // Divide: lo half holds the dividend, quotient bits shifted in at the bottom.
    always_comb begin
        w_add  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
        if (i_is_div) begin
            if (!w_diff[WIDTH])
                w_next_acc = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
                w_next_acc = {r_acc[2*WIDTH-2:0], 1'b0};
        end else begin
            w_next_acc = {w_add, r_acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_fix_hi = i_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = i_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        if (i_is_div)
            o_fixed = {w_fix_hi, w_fix_lo};
        else
            o_fixed = i_neg_q ? -r_acc : r_acc;
    end

    assign o_b_zero = (r_opnd == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc  <= '0;
            r_opnd <= '0;
        end else if (i_load) begin
            r_acc  <= {{WIDTH{1'b0}}, (i_is_div ? i_a : i_b)};
            r_opnd <= i_is_div ? i_b : i_a;
        end else if (i_step) begin
            r_acc  <= w_next_acc;
        end else if (i_fix) begin
            r_acc  <= o_fixed;
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative MULT/DIV engine: FSM, step counter, status strobes and HI/LO registers.
// Define MULT_DIV_UNSIGNED_EN to let op[1] select MULTU/DIVU.
module mult_div_sequencer
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_load;
    logic               w_step;
    logic               w_fix;
    logic               w_uns;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_dp_div;
    logic               w_b_zero;
    logic [2*WIDTH-1:0] w_fixed;

`ifdef MULT_DIV_UNSIGNED_EN
    assign w_uns = op[OP_UNS];
`else
    logic w_unused_op;
    assign w_uns       = 1'b0;
    assign w_unused_op = op[OP_UNS];
`endif

    // Clearing the sign flags in unsigned mode also disables every negation in FIX.
    always_comb begin
        w_sa    = a[WIDTH-1] & ~w_uns;
        w_sb    = b[WIDTH-1] & ~w_uns;
        w_mag_a = w_sa ? -a : a;
        w_mag_b = w_sb ? -b : b;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                w_next = LOAD;
                w_load = 1'b1;
            end
            LOAD: w_next = (r_is_div && w_b_zero) ? ZERO : CALC;
            CALC: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(WIDTH-1)) w_next = FIX;
            end
            FIX: begin
                w_fix  = 1'b1;
                w_next = DONE;
            end
            DONE:    w_next = IDLE;
            ZERO:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign div0     = (r_state == ZERO);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign w_dp_div = w_load ? op[OP_DIV] : r_is_div;

    // HI/LO capture the corrected result on the FIX->DONE edge so they are valid alongside done.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_is_div <= op[OP_DIV];
                r_neg_q  <= w_sa ^ w_sb;
                r_neg_r  <= w_sa;
            end
            if (r_state == LOAD)
                r_cnt <= '0;
            else if (w_step)
                r_cnt <= r_cnt + 1'b1;
            if (w_fix)
                {r_hi, r_lo} <= w_fixed;
        end
    end

    mult_div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_fix    (w_fix),
        .i_is_div (w_dp_div),
        .i_neg_q  (r_neg_q),
        .i_neg_r  (r_neg_r),
        .i_a      (w_mag_a),
        .i_b      (w_mag_b),
        .o_b_zero (w_b_zero),
        .o_fixed  (w_fixed)
    );

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: directed MULT/DIV vectors, busy/latency/abort checks.
module tb_mult_div_sequencer;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mult_div_sequencer #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic         is_div0;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int unsigned  due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports completion.
    logic prev_done = 1'b0;
    exp_t e;
    always @(negedge clock) begin
        if (prev_done) check("done_pulse_width", {63'd0, done}, 64'd0);
        prev_done = (done === 1'b1);
        if (done === 1'b1 || div0 === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_completion", {62'd0, done, div0}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("done_div0_kind", {62'd0, done, div0}, e.is_div0 ? 64'd1 : 64'd2);
                check("latency", {32'd0, cyc}, {32'd0, e.due});
                check("hi", {32'd0, hi}, {32'd0, e.hi});
                check("lo", {32'd0, lo}, {32'd0, e.lo});
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic exp_div0, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input int repulse);
        int unsigned t;
        int lat;
        exp_t x;
        @(negedge clock);
        op = o; a = ia; b = ib; start = 1'b1;
        t = cyc;
        lat = exp_div0 ? 2 : W + 3;
        x.is_div0 = exp_div0; x.hi = eh; x.lo = el; x.due = t + lat;
        sb.push_back(x);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clock);
            if (k == repulse) begin
                start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd0;
            end else begin
                start = 1'b0; a = ~ia; b = ~ib; op = ~o;
            end
            check("busy", {63'd0, busy}, (k <= lat) ? 64'd1 : 64'd0);
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done_div0", {62'd0, done, div0}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;

        run_op(2'b00, 32'd7,        32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op(2'b01, 32'd5,        32'd0,        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000, 0);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000, 0);
        run_op(2'b01, 32'd7,        32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD, 0);
        run_op(2'b01, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 0);
        run_op(2'b01, 32'd100,      32'd7,        1'b0, 32'h0000_0002, 32'h0000_000E, 0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0001, 0);
        run_op(2'b00, 32'h1234_5678, 32'h10,       1'b0, 32'h0000_0001, 32'h2345_6780, 0);
        // start re-pulsed mid-operation with a DIV-by-zero request: must be ignored
        run_op(2'b00, 32'd100,      32'd200,      1'b0, 32'h0000_0000, 32'h0000_4E20, 5);

        // Abort a MULT with reset at T+10; nothing is pushed, so any completion is unexpected.
        @(negedge clock);
        op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        check("busy_before_abort", {63'd0, busy}, 64'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        repeat (2) @(negedge clock);
        check("abort_idle_busy", {63'd0, busy}, 64'd0);

        run_op(2'b01, 32'd100, 32'd7, 1'b0, 32'h0000_0002, 32'h0000_000E, 0);
`ifdef MULT_DIV_UNSIGNED_EN
        run_op(2'b11, 32'hFFFF_FFFF, 32'd2,        1'b0, 32'h0000_0001, 32'h7FFF_FFFF, 0);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 0);
`else
        // op[1] ignored: -1 / 2 signed gives quotient 0, remainder -1
        run_op(2'b11, 32'hFFFF_FFFF, 32'd2,        1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0001, 0);
`endif

        for (int i = 0; i < W + 10; i++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
        end
        check("scoreboard_drain", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
